// File: rtl/adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package adder_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_adder_1bit.sv
// Single-bit full adder cell, reused every cycle by the serial adder.
module full_adder_1bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/serial_adder_4bit.sv
// Bit-serial adder: one full-adder cell, LSB first, WIDTH cycles per add.
// Operands enter on a valid/ready start handshake, results leave on a done handshake.
module serial_adder_4bit
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             done_valid,
    input  logic             done_ready
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_count;

    logic             w_s;
    logic             w_cout;
    logic [WIDTH-1:0] w_sumNext;

    full_adder_1bit u_cell (
        .i_a    (r_opA[0]),
        .i_b    (r_opB[0]),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_cout)
    );

    // New sum bit enters at the MSB; the cast keeps this valid for WIDTH=1.
    assign w_sumNext   = WIDTH'({w_s, r_sum} >> 1);
    assign start_ready = (r_state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_opA      <= '0;
            r_opB      <= '0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_count    <= '0;
            Sum        <= '0;
            Carry      <= 1'b0;
            done_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_valid) begin
                        r_opA   <= A;
                        r_opB   <= B;
                        r_sum   <= '0;
                        r_carry <= 1'b0;
                        r_count <= '0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    r_opA   <= r_opA >> 1;
                    r_opB   <= r_opB >> 1;
                    r_sum   <= w_sumNext;
                    r_carry <= w_cout;
                    r_count <= r_count + CW'(1);
                    // Outputs only move here, so consumers never see partial sums.
                    if (r_count == LAST) begin
                        Sum        <= w_sumNext;
                        Carry      <= w_cout;
                        done_valid <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        done_valid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_4bit.sv
// Directed self-checking bench for serial_adder_4bit (WIDTH=4).
module tb_serial_adder_4bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_valid;
    logic       start_ready;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] Sum;
    logic       Carry;
    logic       done_valid;
    logic       done_ready;

    int checkCount = 0;
    int errorCount = 0;

    logic [3:0] modelSum;
    logic       modelCarry;

    serial_adder_4bit #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .A           (A),
        .B           (B),
        .Sum         (Sum),
        .Carry       (Carry),
        .done_valid  (done_valid),
        .done_ready  (done_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Issues one start handshake and waits (bounded) for done_valid.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic dr, output int cycles);
        A           = a;
        B           = b;
        done_ready  = dr;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        checkOutput("startReadyBusy", {31'd0, start_ready}, 32'd0);
        cycles = 0;
        while (cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
            if (done_valid) break;
            checkOutput("sumHeldBusy", {28'd0, Sum}, {28'd0, modelSum});
            checkOutput("carryHeldBusy", {31'd0, Carry}, {31'd0, modelCarry});
        end
        if (!done_valid) checkOutput("doneTimeout", 32'd0, 32'd1);
    endtask

    task automatic runAdd(input logic [3:0] a, input logic [3:0] b, input logic [3:0] expSum, input logic expCarry);
        int cycles;
        applyStimulus(a, b, 1'b1, cycles);
        checkOutput("latency", cycles, 32'd4);
        checkOutput("sum", {28'd0, Sum}, {28'd0, expSum});
        checkOutput("carry", {31'd0, Carry}, {31'd0, expCarry});
        modelSum   = expSum;
        modelCarry = expCarry;
        @(posedge clk); #1;
        checkOutput("doneDropped", {31'd0, done_valid}, 32'd0);
        checkOutput("readyAgain", {31'd0, start_ready}, 32'd1);
        checkOutput("sumAfterHs", {28'd0, Sum}, {28'd0, expSum});
    endtask

    initial begin
        int cycles;
        int total;
        rst         = 1'b1;
        start_valid = 1'b0;
        done_ready  = 1'b0;
        A           = '0;
        B           = '0;
        modelSum    = '0;
        modelCarry  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rstSum", {28'd0, Sum}, 32'd0);
        checkOutput("rstCarry", {31'd0, Carry}, 32'd0);
        checkOutput("rstDone", {31'd0, done_valid}, 32'd0);
        checkOutput("rstReady", {31'd0, start_ready}, 32'd1);

        $display("[TB] basic and overflow adds");
        runAdd(4'd3, 4'd5, 4'd8, 1'b0);
        runAdd(4'd15, 4'd1, 4'd0, 1'b1);
        runAdd(4'd15, 4'd15, 4'd14, 1'b1);
        runAdd(4'd10, 4'd5, 4'd15, 1'b0);

        $display("[TB] backpressure");
        applyStimulus(4'd9, 4'd4, 1'b0, cycles);
        checkOutput("bpLatency", cycles, 32'd4);
        checkOutput("bpSum", {28'd0, Sum}, 32'd13);
        checkOutput("bpCarry", {31'd0, Carry}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            start_valid = i[0];
            A           = 4'd1;
            B           = 4'd1;
            @(posedge clk); #1;
            checkOutput("bpDoneHeld", {31'd0, done_valid}, 32'd1);
            checkOutput("bpSumHeld", {28'd0, Sum}, 32'd13);
            checkOutput("bpReadyLow", {31'd0, start_ready}, 32'd0);
        end
        // Start and done handshakes together: only the done side may fire.
        start_valid = 1'b1;
        done_ready  = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        checkOutput("bpReleased", {31'd0, done_valid}, 32'd0);
        checkOutput("bpIdle", {31'd0, start_ready}, 32'd1);
        @(posedge clk); #1;
        checkOutput("bpNoStart", {31'd0, start_ready}, 32'd1);
        checkOutput("bpSumKept", {28'd0, Sum}, 32'd13);
        modelSum   = 4'd13;
        modelCarry = 1'b0;

        $display("[TB] reset mid-busy");
        A           = 4'd7;
        B           = 4'd7;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midRstSum", {28'd0, Sum}, 32'd0);
        checkOutput("midRstCarry", {31'd0, Carry}, 32'd0);
        checkOutput("midRstReady", {31'd0, start_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checkOutput("midRstNoDone", {31'd0, done_valid}, 32'd0);
        end
        modelSum   = '0;
        modelCarry = 1'b0;
        runAdd(4'd2, 4'd2, 4'd4, 1'b0);

        $display("[TB] exhaustive sweep");
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                total = a + b;
                runAdd(a[3:0], b[3:0], total[3:0], total[4]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/serial_adder_4bit.md
Name: serial_adder_4bit

Overview:
Multi-cycle bit-serial adder, the additive counterpart to the team's combinational 4-bit subtractor.
- Computes Sum = A + B with carry-out, one bit per clock, LSB first.
- Operands are accepted through a valid/ready start handshake; the result is presented through a valid/ready done handshake.
- Intended for area-constrained datapaths that share one full-adder cell across a multi-bit add.

Parameters:
- WIDTH, 4, operand/result width in bits (must be >= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start_valid  input  1  operands A/B are valid this cycle.
- start_ready  output  1  block can accept operands (high only in IDLE).
- A  input  WIDTH  addend, sampled on the start handshake.
- B  input  WIDTH  addend, sampled on the start handshake.
- Sum  output  WIDTH  A+B modulo 2^WIDTH, registered.
- Carry  output  1  carry-out, bit WIDTH of A+B, registered.
- done_valid  output  1  Sum/Carry hold a new result.
- done_ready  input  1  consumer accepts the result.

Behaviour:
- Reset and clock: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, Sum=0, Carry=0, done_valid=0, start_ready=1 (start_ready decoded from state), internal shift registers, carry flop and bit counter = 0.
- States: IDLE, BUSY, DONE (enum in package).
- IDLE:
  - start_ready=1.
  - On start_valid && start_ready at edge E0: load A into op_a shift reg, load B into op_b shift reg, clear carry flop, clear counter, go to BUSY.
- BUSY:
  - start_ready=0. start_valid is ignored; operands are not re-sampled.
  - Each edge: s = a[0]^b[0]^c; c' = majority(a[0],b[0],c).
  - Shift op_a and op_b right by 1. Shift s into the MSB of the sum shift reg. Increment counter.
  - At the edge where counter reaches WIDTH-1 (the WIDTH-th bit, edge E0+WIDTH): load Sum from the completed shift value, load Carry with c', go to DONE.
- Latency: done_valid is first high in the cycle after edge E0+WIDTH, i.e. WIDTH cycles after the accept edge (4 for default).
- DONE:
  - done_valid=1. Sum/Carry are stable.
  - On done_valid && done_ready: go to IDLE, done_valid=0.
  - Sum/Carry keep their value until the next completion.
  - If done_ready is low, the block stalls in DONE indefinitely.
- Sum/Carry never show intermediate bits; they change only at the completion edge.
- No back-to-back overlap: a new start is accepted earliest in the cycle after the done handshake.
- Arithmetic: unsigned; {Carry,Sum} == A+B exactly (WIDTH+1 bits). Wrap-around, e.g. WIDTH=4: 15+1 gives Sum=0, Carry=1.
- Counter width: $clog2(WIDTH+1). WIDTH=1 completes in 1 cycle.
- Reset mid-operation (BUSY or DONE):
  - Aborts the add; no done_valid pulse; returns to reset values.
  - Reset has priority over every handshake in the same cycle.
- start_valid and done_ready simultaneously high in DONE: only the done handshake takes effect; start is not accepted that cycle.

Decomposition:
- Package adder_pkg holds:
  - state typedef (enum logic [1:0] {IDLE, BUSY, DONE});
  - localparam DEFAULT_WIDTH = 4.
- Sub-module full_adder_1bit (combinational: a, b, cin -> s, cout), instantiated once for the serial bit cell.
- FSM, counter and shift registers live in serial_adder_4bit.

Test Plan:
- Reset then idle: rst=1 two cycles -> Sum=0, Carry=0, done_valid=0, start_ready=1.
- Basic add: A=3, B=5, done_ready=1 -> done_valid exactly 4 cycles after accept, Sum=8, Carry=0; start_ready returns high next cycle.
- Overflow wrap: A=15, B=1 -> Sum=0, Carry=1; A=15, B=15 -> Sum=14, Carry=1.
- Backpressure: A=9, B=4, done_ready=0 for 5 cycles -> done_valid and Sum=13 held stable, start_valid pulses ignored; done_ready=1 -> IDLE next cycle.
- Reset mid-BUSY: accept A=7, B=7, assert rst at the 2nd BUSY cycle -> no done_valid ever; outputs return to 0; next add A=2, B=2 gives Sum=4.
- Exhaustive sweep: all 256 A/B pairs back-to-back with done_ready=1 -> {Carry,Sum} == A+B every time, and Sum/Carry change only on completion edges.
